// File: rtl/aes_pkg.sv
// Shared Rijndael state helpers: legal column counts, ShiftRows row offsets
// and the state width for a given Nb.
package aes_pkg;

    localparam int NB_DEFAULT = 4;

    function automatic bit nbLegal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Nb=8 skips offset 2: rows 2 and 3 rotate by 3 and 4 columns.
    function automatic int rowOffset(input int nb, input int r);
        if ((nb == 8) && (r >= 2)) begin
            return r + 1;
        end
        return r;
    endfunction

    function automatic int stateWidth(input int nb);
        return 32 * nb;
    endfunction

endpackage

// File: rtl/shift_rows_core.sv
// Combinational ShiftRows / InvShiftRows on a column-major Rijndael state
// (byte k = s[k mod 4][k div 4], byte 0 in the MSBs).
module shift_rows_core
    import aes_pkg::*;
#(
    parameter int NB = NB_DEFAULT
) (
    input  logic [stateWidth(NB)-1:0] iData,
    input  logic                      iInv,
    output logic [stateWidth(NB)-1:0] oData
);

    localparam int W = stateWidth(NB);

    logic [W-1:0] w_fwd;
    logic [W-1:0] w_inv;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int KO = c * 4 + r;
            localparam int KF = ((c + rowOffset(NB, r)) % NB) * 4 + r;
            localparam int KI = ((c - rowOffset(NB, r) + NB) % NB) * 4 + r;

            assign w_fwd[W-1-8*KO -: 8] = iData[W-1-8*KF -: 8];
            assign w_inv[W-1-8*KO -: 8] = iData[W-1-8*KI -: 8];
        end
    end

    assign oData = iInv ? w_inv : w_fwd;

endmodule

// File: rtl/shift_rows_stream.sv
// Streaming ShiftRows stage: permutes on the input path and holds results in a
// two-entry skid buffer (main + skid) so oReady is driven from a flop only.
module shift_rows_stream
    import aes_pkg::*;
#(
    parameter int NB    = NB_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic                      iClk,
    input  logic                      iRst_n,
    input  logic                      iValid,
    output logic                      oReady,
    input  logic [stateWidth(NB)-1:0] iData,
    input  logic                      iInv,
    output logic                      oValid,
    input  logic                      iReady,
    output logic [stateWidth(NB)-1:0] oData,
    output logic [CNT_W-1:0]          oBlkCnt
);

    localparam int W = stateWidth(NB);

    if (!nbLegal(NB)) begin : g_badNb
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end

    logic [W-1:0]     w_perm;
    logic             w_accept;
    logic             w_xfer;
    logic [W-1:0]     r_mainData;
    logic             r_mainValid;
    logic [W-1:0]     r_skidData;
    logic             r_skidValid;
    logic [CNT_W-1:0] r_blkCnt;

    shift_rows_core #(
        .NB(NB)
    ) u_core (
        .iData(iData),
        .iInv (iInv),
        .oData(w_perm)
    );

    assign w_accept = iValid && oReady;
    assign w_xfer   = r_mainValid && iReady;

    // The skid entry can only fill while main is stalled, and any accept
    // then lands in skid; when main frees up, skid (if held) refills it first.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_mainData  <= '0;
            r_mainValid <= 1'b0;
            r_skidData  <= '0;
            r_skidValid <= 1'b0;
        end else if (!r_mainValid || w_xfer) begin
            if (r_skidValid) begin
                r_mainData  <= r_skidData;
                r_mainValid <= 1'b1;
                r_skidValid <= 1'b0;
            end else if (w_accept) begin
                r_mainData  <= w_perm;
                r_mainValid <= 1'b1;
            end else begin
                r_mainValid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skidData  <= w_perm;
            r_skidValid <= 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_blkCnt <= '0;
        end else if (w_xfer) begin
            r_blkCnt <= r_blkCnt + 1'b1;
        end
    end

    assign oReady  = ~r_skidValid;
    assign oValid  = r_mainValid;
    assign oData   = r_mainData;
    assign oBlkCnt = r_blkCnt;

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed self-checking bench for shift_rows_stream: an NB=4/CNT_W=4 instance
// for flow control, reset and wrap, and an NB=8 instance for the 256-bit state.
module tb_shift_rows_stream;

    localparam logic [127:0] VEC_A    = 128'h8293c31bfc33f5c4eeacea4bc1281663;
    localparam logic [127:0] VEC_B    = 128'h8233ea63fcac161bee28c3c4c193f54b;
    localparam logic [127:0] VEC_INVA = 128'h8228eac4fc93164bee33c363c1acf51b;
    localparam logic [255:0] VEC_ASC  =
        256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    localparam logic [255:0] VEC_ASC_FWD =
        256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

    logic clock = 1'b0;
    logic rstN;

    logic         valid4, inv4, ready4;
    logic [127:0] data4;
    logic         oReady4, oValid4;
    logic [127:0] oData4;
    logic [3:0]   oBlkCnt4;

    logic         valid8, inv8, ready8;
    logic [255:0] data8;
    logic         oReady8, oValid8;
    logic [255:0] oData8;
    logic [15:0]  oBlkCnt8;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    shift_rows_stream #(.NB(4), .CNT_W(4)) dut4 (
        .iClk(clock), .iRst_n(rstN), .iValid(valid4), .oReady(oReady4),
        .iData(data4), .iInv(inv4), .oValid(oValid4), .iReady(ready4),
        .oData(oData4), .oBlkCnt(oBlkCnt4)
    );

    shift_rows_stream #(.NB(8)) dut8 (
        .iClk(clock), .iRst_n(rstN), .iValid(valid8), .oReady(oReady8),
        .iData(data8), .iInv(inv8), .oValid(oValid8), .iReady(ready8),
        .oData(oData8), .oBlkCnt(oBlkCnt8)
    );

    // Every comparison is counted here; mismatches print one FAIL line.
    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [127:0] d, input logic inv, input logic rdy);
        valid4 = v;
        data4  = d;
        inv4   = inv;
        ready4 = rdy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic resetPulse();
        rstN = 1'b0;
        #2;
        rstN = 1'b1;
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        valid8 = 1'b0;
        inv8   = 1'b0;
        ready8 = 1'b1;
        data8  = '0;

        #2;
        checkOutput("rst_oValid", 256'(oValid4), 256'd0);
        checkOutput("rst_oData", 256'(oData4), 256'd0);
        checkOutput("rst_oReady", 256'(oReady4), 256'd1);
        checkOutput("rst_cnt", 256'(oBlkCnt4), 256'd0);

        applyStimulus(1'b1, VEC_A, 1'b0, 1'b1);
        tick();
        checkOutput("rst_hold_oValid", 256'(oValid4), 256'd0);

        // Deassert between edges; the very next edge must accept.
        rstN = 1'b1;
        tick();
        checkOutput("fwd4_oValid", 256'(oValid4), 256'd1);
        checkOutput("fwd4_oData", 256'(oData4), 256'(VEC_B));
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        tick();
        checkOutput("fwd4_cnt", 256'(oBlkCnt4), 256'd1);
        checkOutput("fwd4_drained", 256'(oValid4), 256'd0);

        applyStimulus(1'b1, VEC_B, 1'b1, 1'b1);
        tick();
        checkOutput("inv4_oData", 256'(oData4), 256'(VEC_A));
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        tick();
        checkOutput("inv4_cnt", 256'(oBlkCnt4), 256'd2);

        valid8 = 1'b1;
        data8  = VEC_ASC;
        inv8   = 1'b0;
        tick();
        checkOutput("fwd8_oData", oData8, VEC_ASC_FWD);
        data8 = VEC_ASC_FWD;
        inv8  = 1'b1;
        tick();
        checkOutput("inv8_oData", oData8, VEC_ASC);
        valid8 = 1'b0;
        tick();
        checkOutput("nb8_cnt", 256'(oBlkCnt8), 256'd2);

        // Back-pressure: A, B fill main and skid, C waits until drain begins.
        resetPulse();
        applyStimulus(1'b1, VEC_A, 1'b0, 1'b0);
        tick();
        checkOutput("bp_ready_after_A", 256'(oReady4), 256'd1);
        applyStimulus(1'b1, VEC_B, 1'b1, 1'b0);
        tick();
        checkOutput("bp_ready_after_B", 256'(oReady4), 256'd0);
        applyStimulus(1'b1, VEC_A, 1'b1, 1'b0);
        tick();
        checkOutput("bp_hold_oValid", 256'(oValid4), 256'd1);
        checkOutput("bp_hold_oData", 256'(oData4), 256'(VEC_B));
        checkOutput("bp_hold_ready", 256'(oReady4), 256'd0);
        applyStimulus(1'b1, VEC_A, 1'b1, 1'b1);
        tick();
        checkOutput("bp_outB_data", 256'(oData4), 256'(VEC_A));
        checkOutput("bp_outB_ready", 256'(oReady4), 256'd1);
        checkOutput("bp_outB_cnt", 256'(oBlkCnt4), 256'd1);
        tick();
        checkOutput("bp_outC_valid", 256'(oValid4), 256'd1);
        checkOutput("bp_outC_data", 256'(oData4), 256'(VEC_INVA));
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        tick();
        checkOutput("bp_final_cnt", 256'(oBlkCnt4), 256'd3);
        checkOutput("bp_final_valid", 256'(oValid4), 256'd0);

        // Asynchronous reset with both entries occupied.
        resetPulse();
        applyStimulus(1'b1, VEC_A, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, VEC_B, 1'b1, 1'b0);
        tick();
        checkOutput("ar_full_ready", 256'(oReady4), 256'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("ar_oValid", 256'(oValid4), 256'd0);
        checkOutput("ar_oReady", 256'(oReady4), 256'd1);
        checkOutput("ar_cnt", 256'(oBlkCnt4), 256'd0);
        checkOutput("ar_oData", 256'(oData4), 256'd0);
        @(negedge clock);
        rstN = 1'b1;
        applyStimulus(1'b1, VEC_A, 1'b1, 1'b1);
        tick();
        checkOutput("ar_post_data", 256'(oData4), 256'(VEC_INVA));
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        tick();
        checkOutput("ar_post_cnt", 256'(oBlkCnt4), 256'd1);

        // 17 back-to-back blocks with alternating mode; 4-bit counter wraps.
        resetPulse();
        for (int i = 0; i < 17; i++) begin
            if (i % 2 == 0) begin
                applyStimulus(1'b1, VEC_A, 1'b0, 1'b1);
            end else begin
                applyStimulus(1'b1, VEC_B, 1'b1, 1'b1);
            end
            tick();
            checkOutput($sformatf("wrap_valid_%0d", i), 256'(oValid4), 256'd1);
            checkOutput($sformatf("wrap_data_%0d", i), 256'(oData4),
                        (i % 2 == 0) ? 256'(VEC_B) : 256'(VEC_A));
            checkOutput($sformatf("wrap_cnt_%0d", i), 256'(oBlkCnt4), 256'(i % 16));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        tick();
        checkOutput("wrap_cnt_17", 256'(oBlkCnt4), 256'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_rows_stream.md
SHIFT_ROWS_STREAM -- requirements
Module: shift_rows_stream

Interface
REQ-001 The block SHALL have parameter NB, default 4: state columns (Rijndael Nb); legal values 4, 6, 8.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the completed-block counter.
REQ-003 The block SHALL have port iClk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port iRst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port iValid  input  1  upstream block valid.
REQ-006 The block SHALL have port oReady  output  1  block can accept input this cycle.
REQ-007 The block SHALL have port iData  input  32*NB  input state, column-major, byte 0 in the MSBs (byte k = s[k mod 4][k div 4]).
REQ-008 The block SHALL have port iInv  input  1  mode sampled with iData: 0 = ShiftRows, 1 = InvShiftRows.
REQ-009 The block SHALL have port oValid  output  1  output block valid.
REQ-010 The block SHALL have port iReady  input  1  downstream ready.
REQ-011 The block SHALL have port oData  output  32*NB  transformed state, same byte order as iData.
REQ-012 The block SHALL have port oBlkCnt  output  CNT_W  count of completed output handshakes.

Function
REQ-013 Row offsets SHALL be C = {0,1,2,3} for NB=4 and NB=6, and C = {0,1,3,4} for NB=8.
REQ-014 In forward mode, out[r][c] SHALL equal in[r][(c+C[r]) mod NB].
REQ-015 In inverse mode, out[r][c] SHALL equal in[r][(c-C[r]) mod NB].
REQ-016 Input acceptance SHALL occur exactly when iValid && oReady at a rising edge.
REQ-017 Output transfer SHALL occur exactly when oValid && iReady at a rising edge.
REQ-018 The permutation SHALL be applied on input; oData SHALL be registered, with latency 1 cycle from acceptance to oValid when the output register is empty or draining.
REQ-019 Storage SHALL be a 2-entry skid buffer (main + skid); sustained throughput SHALL be 1 block/cycle while iReady=1.
REQ-020 oReady SHALL be a register output, equal to NOT skid-occupied; no combinational path from iReady to oReady.
REQ-021 If an input is accepted while main is full and not draining, it SHALL go to skid; oReady SHALL drop the next cycle.
REQ-022 When main drains and skid is occupied, skid SHALL move to main in the same edge and oReady SHALL rise the next cycle.
REQ-023 A simultaneous accept and transfer SHALL keep occupancy unchanged with no bubble.
REQ-024 While oValid=1 and iReady=0, oData and oValid SHALL hold stable.
REQ-025 Blocks SHALL leave in acceptance order; none SHALL be dropped or duplicated; per-block mode SHALL be honoured across mode changes.
REQ-026 oBlkCnt SHALL increment by 1 per output transfer and wrap from 2^CNT_W-1 to 0.
REQ-027 An illegal NB SHALL cause an elaboration-time error.

Reset
REQ-028 While iRst_n=0: oValid=0, oData=0, both buffer entries empty, oBlkCnt=0, oReady=1.
REQ-029 Reset assertion mid-transfer SHALL discard all held blocks immediately (asynchronous), with no output transfer counted.
REQ-030 The first acceptance SHALL be possible on the first rising edge after iRst_n deasserts.

Structure
REQ-031 NB legal values, the row-offset function C(NB,r) and the state width 32*NB SHALL live in shared package aes_pkg.
REQ-032 The combinational permutation SHALL be sub-module shift_rows_core (params NB; ports data in, iInv, data out), instantiated once on the input path.

Verification
REQ-033 NB=4, iInv=0, iData=8293c31bfc33f5c4eeacea4bc1281663 -> one cycle later oValid=1, oData=8233ea63fcac161bee28c3c4c193f54b, oBlkCnt=1.
REQ-034 NB=4, iInv=1, iData=8233ea63fcac161bee28c3c4c193f54b -> oData=8293c31bfc33f5c4eeacea4bc1281663.
REQ-035 NB=8, iInv=0, iData bytes 00..1F ascending -> first output column 00,05,0E,13; same output fed back with iInv=1 -> original 00..1F.
REQ-036 Hold iReady=0 and present 3 back-to-back blocks A,B,C -> A,B accepted, oReady=0 the cycle after B; release iReady -> A,B,C out in order, no gaps, oBlkCnt=3.
REQ-037 Assert iRst_n=0 with both entries full -> oValid=0 and oReady=1 immediately, oBlkCnt=0; first post-reset block emerges correctly.
REQ-038 CNT_W=4, 17 transfers with alternating iInv -> each result correct, oBlkCnt reads 0 after the 16th and 1 after the 17th.
